// File: rtl/readout_capture_if.sv
// Pixel stream interface between readout_capture (master) and its consumer (slave).
// The master drives valid/data/index/last; the consumer answers with ready.
interface readout_capture_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2
);
    logic              Pix_valid;
    logic              Pix_ready;
    logic [DATA_W-1:0] Pix_data;
    logic [IDX_W-1:0]  Pix_index;
    logic              Pix_last;

    modport master (
        output Pix_valid,
        output Pix_data,
        output Pix_index,
        output Pix_last,
        input  Pix_ready
    );

    modport slave (
        input  Pix_valid,
        input  Pix_data,
        input  Pix_index,
        input  Pix_last,
        output Pix_ready
    );
endinterface

// File: rtl/readout_capture.sv
// readout_capture: receiving end of the camera controller readout sequence.
// Watches Expose / NRE_R1 / NRE_R2 / ADC, captures one row of column results
// per ADC strobe into a capture buffer, hands each completed frame to an
// output buffer and streams it out pixel by pixel over valid/ready.
// Optional feature: define READOUT_TESTPAT_EN to add the Test_mode input and a
// 4-bit delivered-frame counter used to synthesise a test pattern.
module readout_capture #(
    parameter int DATA_W = 8,
    parameter int COLS   = 2,
    parameter int ROWS   = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Expose,
    input  logic                   NRE_R1,
    input  logic                   NRE_R2,
    input  logic                   ADC,
    input  logic [COLS*DATA_W-1:0] Adc_data,
`ifdef READOUT_TESTPAT_EN
    input  logic                   Test_mode,
`endif
    readout_capture_if.master      pix,
    output logic                   Busy,
    output logic                   Frame_overflow,
    output logic                   Err_proto
);

    localparam int NPIX  = ROWS * COLS;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    logic [0:0]        state;
    logic [1:0]        row_mask;
    logic              expose_q;
    logic              adc_q;
    logic              expose_edge;
    logic              adc_edge;
    logic              row0_sel;
    logic              row1_sel;
    logic              frame_done;
    logic              wr_row0;
    logic              wr_row1;
    logic              proto_ev;
    logic              handoff;
    logic              pix_take;

    logic [DATA_W-1:0] cap_buf [NPIX];
    logic [DATA_W-1:0] out_buf [NPIX];
    logic              out_full;
    logic [IDX_W-1:0]  out_idx;

`ifdef READOUT_TESTPAT_EN
    logic [3:0]        frame_cnt;

    // Test pattern: delivered-frame count in the upper nibble, pixel index in the lower.
    function automatic logic [DATA_W-1:0] testpat_value(input int unsigned idx,
                                                        input logic [DATA_W-1:0] adc);
        logic [7:0] pat;
        pat = {frame_cnt, idx[3:0]};
        return Test_mode ? DATA_W'(pat) : adc;
    endfunction
`endif

    // Strobe edges are judged against the value registered at the previous clock.
    assign expose_edge = Expose & ~expose_q;
    assign adc_edge    = ADC & ~adc_q;

    // Exactly one read enable must be low to select a row.
    assign row0_sel = ~NRE_R1 &  NRE_R2;
    assign row1_sel =  NRE_R1 & ~NRE_R2;

    // Both rows written: the frame is handed off on the following edge.
    assign frame_done = (state == ST_READ) && (row_mask == 2'b11);

    // A simultaneous Expose edge restarts the frame and silently drops the sample.
    assign wr_row0 = (state == ST_READ) && !frame_done && adc_edge && !expose_edge &&
                     row0_sel && !row_mask[0];
    assign wr_row1 = (state == ST_READ) && !frame_done && adc_edge && !expose_edge &&
                     row1_sel && !row_mask[1];

    // Any ADC edge that did not produce a write (IDLE, bad enables, repeated row).
    assign proto_ev = adc_edge && !expose_edge && !(wr_row0 || wr_row1);

    // Hand-off looks at the registered fill state, so an emptying buffer is never reused that cycle.
    assign handoff  = frame_done && !out_full;
    assign pix_take = out_full && pix.Pix_ready;

    // Strobe history registers for edge detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            expose_q <= 1'b0;
            adc_q    <= 1'b0;
        end else begin
            expose_q <= Expose;
            adc_q    <= ADC;
        end
    end

    // Capture FSM and row mask.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            row_mask <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (expose_edge) begin
                        state    <= ST_READ;
                        row_mask <= 2'b00;
                    end
                end
                ST_READ: begin
                    if (frame_done) begin
                        state    <= expose_edge ? ST_READ : ST_IDLE;
                        row_mask <= 2'b00;
                    end else if (expose_edge) begin
                        row_mask <= 2'b00;
                    end else begin
                        if (wr_row0) row_mask[0] <= 1'b1;
                        if (wr_row1) row_mask[1] <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    row_mask <= 2'b00;
                end
            endcase
        end
    end

    // Sticky error and overflow flags.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Err_proto      <= 1'b0;
            Frame_overflow <= 1'b0;
        end else begin
            if (proto_ev)              Err_proto      <= 1'b1;
            if (frame_done && out_full) Frame_overflow <= 1'b1;
        end
    end

    // Capture buffer row writes (data only, not reset).
    always_ff @(posedge Clk) begin
        for (int c = 0; c < COLS; c++) begin
`ifdef READOUT_TESTPAT_EN
            if (wr_row0) cap_buf[c]        <= testpat_value(c, Adc_data[c*DATA_W +: DATA_W]);
            if (wr_row1) cap_buf[COLS + c] <= testpat_value(COLS + c, Adc_data[c*DATA_W +: DATA_W]);
`else
            if (wr_row0) cap_buf[c]        <= Adc_data[c*DATA_W +: DATA_W];
            if (wr_row1) cap_buf[COLS + c] <= Adc_data[c*DATA_W +: DATA_W];
`endif
        end
    end

    // Output buffer contents: only a successful hand-off overwrites them.
    always_ff @(posedge Clk) begin
        if (handoff) out_buf <= cap_buf;
    end

    // Output buffer fill state and stream index.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            out_full <= 1'b0;
            out_idx  <= '0;
        end else if (handoff) begin
            out_full <= 1'b1;
            out_idx  <= '0;
        end else if (pix_take) begin
            if (out_idx == LAST_IDX) begin
                out_full <= 1'b0;
                out_idx  <= '0;
            end else begin
                out_idx  <= out_idx + IDX_W'(1);
            end
        end
    end

`ifdef READOUT_TESTPAT_EN
    // Delivered-frame counter, advanced when the last pixel is accepted.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_cnt <= 4'd0;
        end else if (pix_take && (out_idx == LAST_IDX)) begin
            frame_cnt <= frame_cnt + 4'd1;
        end
    end
`endif

    // Stream outputs are forced to zero whenever no frame is buffered.
    assign pix.Pix_valid = out_full;
    assign pix.Pix_data  = out_full ? out_buf[out_idx] : '0;
    assign pix.Pix_index = out_idx;
    assign pix.Pix_last  = out_full && (out_idx == LAST_IDX);
    assign Busy          = (state == ST_READ);

endmodule
